// File: rtl/ddr_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read port and read FIFO between the
// distance-coefficient (0) and RSSI-table (1) lookups, with a per-read timeout.
module ddr_rd_arbiter #(
  parameter int DDR_AW      = 27,
  parameter int DDR_DW      = 64,
  parameter int BURST_LEN   = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0,
  input  logic [DDR_AW-1:0] i_addr0,
  input  logic              i_req1,
  input  logic [DDR_AW-1:0] i_addr1,
  output logic              o_grant0,
  output logic              o_grant1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DDR_DW-1:0] o_rdata,
  output logic              o_done0,
  output logic              o_done1,
  output logic              o_timeout,
  output logic              o_ddr_rden,
  output logic [DDR_AW-1:0] o_rdddr_addr_base,
  output logic              o_fifo_rden,
  input  logic [DDR_DW-1:0] i_fifo_rddata,
  input  logic              i_fifo_empty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0]  BURST_N = 4'(BURST_LEN);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic              grant0_q, grant0_d;
  logic              grant1_q, grant1_d;
  logic              last_q, last_d;
  logic              abort_q, abort_d;
  logic              rvalid_q, rvalid_d;
  logic [3:0]        issued_q, issued_d;
  logic [3:0]        recv_q, recv_d;
  logic [15:0]       to_q, to_d;
  logic [DDR_AW-1:0] addr_q, addr_d;
  logic              pop;

  // Pops are gated by FIFO emptiness so an empty FIFO is never read.
  assign pop = (state_q == S_READ) && !i_fifo_empty && (issued_q < BURST_N);

  always_comb begin
    state_d  = state_q;
    grant0_d = grant0_q;
    grant1_d = grant1_q;
    last_d   = last_q;
    abort_d  = abort_q;
    issued_d = issued_q;
    recv_d   = rvalid_q ? recv_q + 4'd1 : recv_q;
    to_d     = to_q;
    addr_d   = addr_q;
    rvalid_d = pop;

    case (state_q)
      S_IDLE: begin
        // On a tie the requester not served last wins.
        if (i_req0 && (!i_req1 || last_q)) begin
          grant0_d = 1'b1;
          addr_d   = i_addr0;
          state_d  = S_ISSUE;
        end else if (i_req1) begin
          grant1_d = 1'b1;
          addr_d   = i_addr1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issued_d = 4'd0;
        recv_d   = 4'd0;
        to_d     = 16'd0;
        state_d  = S_READ;
      end
      S_READ: begin
        if (pop) begin
          issued_d = issued_q + 4'd1;
          to_d     = 16'd0;
          if (issued_q == BURST_N - 4'd1) begin
            state_d = S_DRAIN;
          end
        end else if (to_q == TO_LAST) begin
          abort_d = 1'b1;
          state_d = S_DRAIN;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        last_d   = grant1_q;
        abort_d  = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d  = S_IDLE;
        grant0_d = 1'b0;
        grant1_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      last_q   <= 1'b1;
      abort_q  <= 1'b0;
      rvalid_q <= 1'b0;
      issued_q <= 4'd0;
      recv_q   <= 4'd0;
      to_q     <= 16'd0;
    end else begin
      state_q  <= state_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      last_q   <= last_d;
      abort_q  <= abort_d;
      rvalid_q <= rvalid_d;
      issued_q <= issued_d;
      recv_q   <= recv_d;
      to_q     <= to_d;
    end
  end

  // Address is datapath only; outputs that expose it are masked by state.
  always_ff @(posedge i_clk) begin
    addr_q <= addr_d;
  end

  assign o_grant0          = grant0_q;
  assign o_grant1          = grant1_q;
  assign o_rvalid0         = rvalid_q & grant0_q;
  assign o_rvalid1         = rvalid_q & grant1_q;
  assign o_rdata           = rvalid_q ? i_fifo_rddata : '0;
  assign o_done0           = (state_q == S_DONE) & grant0_q;
  assign o_done1           = (state_q == S_DONE) & grant1_q;
  assign o_timeout         = (state_q == S_DONE) & abort_q;
  assign o_ddr_rden        = (state_q == S_ISSUE);
  assign o_rdddr_addr_base = (state_q != S_IDLE) ? addr_q : '0;
  assign o_fifo_rden       = pop;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Directed bench for ddr_rd_arbiter with a simple read-FIFO model.
module tb_ddr_rd_arbiter;
  localparam int AW = 27;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          o_grant0, o_grant1, o_rvalid0, o_rvalid1;
  logic [DW-1:0] o_rdata;
  logic          o_done0, o_done1, o_timeout, o_ddr_rden, o_fifo_rden;
  logic [AW-1:0] o_rdddr_addr_base;
  logic [DW-1:0] fifo_rddata = '0;
  logic          fifo_empty;

  always #5 clk = ~clk;

  ddr_rd_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0(req0), .i_addr0(addr0), .i_req1(req1), .i_addr1(addr1),
    .o_grant0(o_grant0), .o_grant1(o_grant1),
    .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1), .o_rdata(o_rdata),
    .o_done0(o_done0), .o_done1(o_done1), .o_timeout(o_timeout),
    .o_ddr_rden(o_ddr_rden), .o_rdddr_addr_base(o_rdddr_addr_base),
    .o_fifo_rden(o_fifo_rden), .i_fifo_rddata(fifo_rddata), .i_fifo_empty(fifo_empty)
  );

  // Read FIFO model: 1-cycle read latency, optional forced-empty.
  logic [DW-1:0] mem [0:63];
  int            wp = 0, rp = 0;
  logic          hold_empty = 1'b0, flush = 1'b0;
  assign fifo_empty = (wp == rp) || hold_empty;

  always @(posedge clk) begin
    if (flush) rp <= wp;
    else if (o_fifo_rden) begin
      fifo_rddata <= mem[rp % 64];
      rp <= rp + 1;
    end
  end

  // Event monitor sampled on the falling edge.
  int            cyc = 0;
  logic [DW-1:0] rx0[$], rx1[$];
  int            gq[$], gaps[$];
  int            n_done0 = 0, n_done1 = 0, n_to = 0, n_to_done = 0, n_rden = 0;
  int            n_bad_rden = 0, n_overlap = 0, idle_run = 0;
  int            done_cyc = 0, rden_cyc = 0, last_rv_cyc = 0;
  logic [AW-1:0] rden_addr = '0;
  logic          prev_any = 1'b0, any_g;

  always @(negedge clk) begin
    cyc++;
    if (o_rvalid0) begin rx0.push_back(o_rdata); last_rv_cyc = cyc; end
    if (o_rvalid1) begin rx1.push_back(o_rdata); last_rv_cyc = cyc; end
    if (o_done0) begin n_done0++; done_cyc = cyc; end
    if (o_done1) begin n_done1++; done_cyc = cyc; end
    if (o_timeout) begin n_to++; if (o_done0 || o_done1) n_to_done++; end
    if (o_ddr_rden) begin n_rden++; rden_cyc = cyc; rden_addr = o_rdddr_addr_base; end
    if (o_fifo_rden && fifo_empty) n_bad_rden++;
    if ((o_grant0 && o_grant1) || (o_rvalid0 && o_rvalid1) || (o_done0 && o_done1)) n_overlap++;
    any_g = o_grant0 || o_grant1;
    if (any_g && !prev_any) begin gq.push_back(o_grant1 ? 1 : 0); gaps.push_back(idle_run); end
    if (!any_g) idle_run++; else idle_run = 0;
    prev_any = any_g;
  end

  int tests = 0, fails = 0;
  logic toggle_empty = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (toggle_empty) hold_empty = ~hold_empty;
  endtask

  task automatic push(input logic [DW-1:0] d);
    mem[wp % 64] = d;
    wp++;
  endtask

  task automatic clr();
    rx0.delete(); rx1.delete(); gq.delete(); gaps.delete();
    n_done0 = 0; n_done1 = 0; n_to = 0; n_to_done = 0; n_rden = 0;
    n_bad_rden = 0; n_overlap = 0;
  endtask

  task automatic wait_done(input int which, input int budget, input string tag);
    int n = 0;
    while (n < budget && !((which == 0) ? o_done0 : o_done1)) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic wait_grant(input int which, input int budget, input string tag);
    int n = 0;
    while (n < budget && !((which == 0) ? o_grant0 : o_grant1)) begin
      tick();
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state.
    do_reset();
    chk("reset_ctrl", {o_grant0, o_grant1, o_rvalid0, o_rvalid1, o_done0, o_done1,
                       o_timeout, o_ddr_rden, o_fifo_rden}, 64'd0);
    chk("reset_data", {o_rdata, o_rdddr_addr_base}, 64'd0);

    // Single requester 0, four preloaded words.
    clr();
    for (int i = 0; i < 4; i++) push(64'hA000_0000_0000_0000 + 64'(i));
    addr0 = 27'h001_0040;
    req0  = 1'b1;
    tick();
    chk("t1_grant0", {o_grant0, o_grant1}, 64'b10);
    chk("t1_rden", o_ddr_rden, 64'd1);
    chk("t1_addr", o_rdddr_addr_base, 64'h001_0040);
    addr0 = 27'h7FF_FFFF;
    wait_done(0, 50, "t1_done_wait");
    req0 = 1'b0;
    tick();
    chk("t1_grant_low", {o_grant0, o_grant1}, 64'd0);
    chk("t1_rx0_n", rx0.size(), 64'd4);
    chk("t1_rx0_w0", rx0[0], 64'hA000_0000_0000_0000);
    chk("t1_rx0_w3", rx0[3], 64'hA000_0000_0000_0003);
    chk("t1_rx1_n", rx1.size(), 64'd0);
    chk("t1_ndone", {32'(n_done0), 32'(n_done1)}, {32'd1, 32'd0});
    chk("t1_nrden", n_rden, 64'd1);
    chk("t1_raddr", rden_addr, 64'h001_0040);

    // Simultaneous requests right after reset: requester 0 first.
    do_reset();
    clr();
    for (int i = 0; i < 4; i++) push(64'hB000_0000_0000_0000 + 64'(i));
    for (int i = 0; i < 4; i++) push(64'hC000_0000_0000_0000 + 64'(i));
    addr0 = 27'h000_1000;
    addr1 = 27'h000_4000;
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    chk("t2_first", {o_grant0, o_grant1}, 64'b10);
    wait_done(0, 50, "t2_done0_wait");
    req0 = 1'b0;
    wait_grant(1, 10, "t2_grant1_wait");
    chk("t2_rden1", o_ddr_rden, 64'd1);
    chk("t2_addr1", o_rdddr_addr_base, 64'h000_4000);
    wait_done(1, 50, "t2_done1_wait");
    req1 = 1'b0;
    tick();
    chk("t2_rx0_w0", rx0[0], 64'hB000_0000_0000_0000);
    chk("t2_rx1_n", rx1.size(), 64'd4);
    chk("t2_rx1_w3", rx1[3], 64'hC000_0000_0000_0003);

    // Both held for four transactions: alternation, one idle cycle between grants.
    clr();
    for (int i = 0; i < 16; i++) push(64'(i));
    req0 = 1'b1;
    req1 = 1'b1;
    n = 0;
    while (n < 200 && (n_done0 + n_done1) < 4) begin tick(); n++; end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("t3_finished", 64'(n < 200), 64'd1);
    tick();
    chk("t3_ngrants", gq.size(), 64'd4);
    chk("t3_order", {8'(gq[0]), 8'(gq[1]), 8'(gq[2]), 8'(gq[3])}, 64'h00_01_00_01);
    chk("t3_gaps", {8'(gaps[1]), 8'(gaps[2]), 8'(gaps[3])}, 64'h01_01_01);
    chk("t3_overlap", n_overlap, 64'd0);
    chk("t3_rx_n", {32'(rx0.size()), 32'(rx1.size())}, {32'd8, 32'd8});

    // FIFO empty toggling every cycle during the read.
    clr();
    for (int i = 0; i < 4; i++) push(64'hD000_0000_0000_0010 + 64'(i));
    toggle_empty = 1'b1;
    req0 = 1'b1;
    wait_done(0, 100, "t4_done_wait");
    req0 = 1'b0;
    toggle_empty = 1'b0;
    hold_empty = 1'b0;
    chk("t4_bad_rden", n_bad_rden, 64'd0);
    chk("t4_rx0_n", rx0.size(), 64'd4);
    chk("t4_order", {rx0[1][7:0], rx0[2][7:0], rx0[3][7:0]}, 64'h11_12_13);
    chk("t4_done_lat", done_cyc - last_rv_cyc, 64'd1);
    chk("t4_timeout", n_to, 64'd0);

    // Stalled DDR: FIFO stays empty. Issue at I, READ I+1..I+1000, DRAIN, DONE at I+1002.
    tick();
    clr();
    req0 = 1'b1;
    wait_done(0, 1200, "t5_done_wait");
    req0 = 1'b0;
    chk("t5_latency", done_cyc - rden_cyc, 64'd1002);
    chk("t5_timeout", {32'(n_to), 32'(n_to_done)}, {32'd1, 32'd1});
    chk("t5_no_rvalid", rx0.size() + rx1.size(), 64'd0);
    tick();
    clr();
    for (int i = 0; i < 4; i++) push(64'hE000_0000_0000_0000 + 64'(i));
    req1 = 1'b1;
    wait_done(1, 50, "t5_next_done");
    req1 = 1'b0;
    chk("t5_next_rx1", rx1.size(), 64'd4);
    chk("t5_next_noto", n_to, 64'd0);

    // Reset after two of four words.
    tick();
    clr();
    for (int i = 0; i < 4; i++) push(64'hF000_0000_0000_0000 + 64'(i));
    req0 = 1'b1;
    n = 0;
    while (n < 50 && rx0.size() < 2) begin tick(); n++; end
    chk("t6_two_words", 64'(n < 50), 64'd1);
    rst = 1'b1;
    req0 = 1'b0;
    tick();
    chk("t6_rst_ctrl", {o_grant0, o_grant1, o_rvalid0, o_rvalid1, o_done0, o_done1,
                        o_timeout, o_ddr_rden, o_fifo_rden}, 64'd0);
    chk("t6_rst_data", {o_rdata, o_rdddr_addr_base}, 64'd0);
    rst = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    chk("t6_no_done", n_done0 + n_done1, 64'd0);
    chk("t6_rx0_kept", rx0.size(), 64'd2);
    clr();
    for (int i = 0; i < 8; i++) push(64'h1234_0000_0000_0000 + 64'(i));
    req0 = 1'b1;
    req1 = 1'b1;
    tick();
    chk("t6_fresh_grant", {o_grant0, o_grant1}, 64'b10);
    wait_done(0, 50, "t6_done0");
    req0 = 1'b0;
    wait_done(1, 50, "t6_done1");
    req1 = 1'b0;
    tick();
    chk("t6_rx", {rx0[0][7:0], rx0[3][7:0], rx1[0][7:0], rx1[3][7:0]}, 64'h00_03_04_07);
    chk("t6_overlap", n_overlap, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
